// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : Two-requester priority arbiter owning a 4-digit multiplexed
//            7-segment display, with a minimum hold time per grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_display_arbiter #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    input  logic [15:0] msg0_i,
    input  logic [15:0] msg1_i,
    output logic [1:0]  gnt_o,
    output logic        busy_o,
    output logic [6:0]  disp_o,
    output logic [3:0]  an_o
);

    localparam int          PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [31:0] HOLD_MAX = 32'(HOLD_CYCLES);
    localparam logic [6:0]  BLANK    = 7'b1111111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [31:0]   hold_q, hold_d;
    logic [15:0]   latch_q, latch_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    disp_q, disp_d;
    logic [3:0]    an_q, an_d;
    logic          hold_done;
    logic [3:0]    nibble;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b1000110;  // C
            4'hB:    seg = 7'b1000111;  // L
            4'hC:    seg = 7'b0010010;  // S
            4'hD:    seg = 7'b0000110;  // E
            4'hE:    seg = 7'b0111111;  // dash
            default: seg = BLANK;
        endcase
        return seg;
    endfunction

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        latch_d   = latch_q;
        hold_done = (hold_q == HOLD_MAX);

        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = OWN;
                    hold_d  = 32'd0;
                    if (req_i[1]) begin
                        gnt_d   = 2'b10;
                        latch_d = msg1_i;
                    end else begin
                        gnt_d   = 2'b01;
                        latch_d = msg0_i;
                    end
                end
            end
            default: begin
                if (!hold_done) begin
                    hold_d = hold_q + 32'd1;
                end else if (gnt_q[0] && req_i[1]) begin
                    // Requester 1 takes over directly, no idle gap.
                    gnt_d   = 2'b10;
                    latch_d = msg1_i;
                    hold_d  = 32'd0;
                end else if ((gnt_q & req_i) == 2'b00) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
        endcase

        if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            pre_d   = pre_q + {{(PW-1){1'b0}}, 1'b1};
            digit_d = digit_q;
        end

        nibble = latch_q[{digit_q, 2'b00} +: 4];
        if (state_q == OWN) begin
            an_d   = ~(4'b0001 << digit_q);
            disp_d = glyph(nibble);
        end else begin
            an_d   = 4'b1111;
            disp_d = BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            hold_q  <= 32'd0;
            latch_q <= 16'h0000;
            pre_q   <= '0;
            digit_q <= 2'd0;
            disp_q  <= BLANK;
            an_q    <= 4'b1111;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            latch_q <= latch_d;
            pre_q   <= pre_d;
            digit_q <= digit_d;
            disp_q  <= disp_d;
            an_q    <= an_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q == OWN);
    assign disp_o = disp_q;
    assign an_o   = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
// Module   : tb_seg_display_arbiter
// Purpose  : Directed and random checks of seg_display_arbiter against an
//            edge-count reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

    localparam int DIV  = 4;
    localparam int HOLD = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_i = 2'b00;
    logic [15:0] msg0_i = 16'h0000;
    logic [15:0] msg1_i = 16'h0000;
    logic [1:0]  gnt_o;
    logic        busy_o;
    logic [6:0]  disp_o;
    logic [3:0]  an_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner (-1 = none), edges since the grant, latched
    // message, and edges since reset release (drives the scan position).
    int          m_owner;
    int          m_since;
    logic [15:0] m_latch;
    int          m_k;
    logic [6:0]  e_disp;
    logic [3:0]  e_an;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1000110, 7'b1000111,
        7'b0010010, 7'b0000110, 7'b0111111, 7'b1111111
    };
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_display_arbiter #(
        .REFRESH_DIV (DIV),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req_i),
        .msg0_i (msg0_i),
        .msg1_i (msg1_i),
        .gnt_o  (gnt_o),
        .busy_o (busy_o),
        .disp_o (disp_o),
        .an_o   (an_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_since = 0;
        m_latch = 16'h0000;
        m_k     = 0;
        e_disp  = 7'b1111111;
        e_an    = 4'b1111;
    endtask

    task automatic model_edge();
        int dig;
        dig = (m_k / DIV) % 4;
        if (m_owner < 0) begin
            e_an   = 4'b1111;
            e_disp = 7'b1111111;
        end else begin
            e_an   = an_tab[dig];
            e_disp = glyph_tab[m_latch[dig*4 +: 4]];
        end
        if (m_owner < 0) begin
            if (req_i != 2'b00) begin
                m_owner = req_i[1] ? 1 : 0;
                m_latch = req_i[1] ? msg1_i : msg0_i;
                m_since = 0;
            end
        end else if (m_since >= HOLD) begin
            if (m_owner == 0 && req_i[1]) begin
                m_owner = 1;
                m_latch = msg1_i;
                m_since = 0;
            end else if (!req_i[m_owner]) begin
                m_owner = -1;
            end
        end else begin
            m_since = m_since + 1;
        end
        m_k = m_k + 1;
    endtask

    function automatic logic [1:0] exp_gnt();
        return (m_owner == 1) ? 2'b10 : (m_owner == 0) ? 2'b01 : 2'b00;
    endfunction

    task automatic check(input string tag);
        logic [1:0] eg;
        logic       eb;
        eg = exp_gnt();
        eb = (m_owner >= 0);
        n_vec += 4;
        assert (gnt_o === eg) else begin
            n_err++; $error("FAIL %s gnt got %b want %b", tag, gnt_o, eg);
        end
        assert (busy_o === eb) else begin
            n_err++; $error("FAIL %s busy got %b want %b", tag, busy_o, eb);
        end
        assert (disp_o === e_disp) else begin
            n_err++; $error("FAIL %s disp got %b want %b", tag, disp_o, e_disp);
        end
        assert (an_o === e_an) else begin
            n_err++; $error("FAIL %s an got %b want %b", tag, an_o, e_an);
        end
    endtask

    task automatic step(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check(tag);
        end
    endtask

    // Asynchronous reset: outputs must blank before any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int edges;
        #2;
        do_reset("por");

        // Owner 0 with ABCD scans E,S,L,C; msg change while owned is ignored.
        req_i  = 2'b01;
        msg0_i = 16'hABCD;
        step(1, "grant0");
        n_vec++;
        assert (gnt_o === 2'b01) else begin
            n_err++; $error("FAIL first_grant gnt got %b want 01", gnt_o);
        end
        step(24, "scan_abcd");
        msg0_i = 16'h1234;
        step(20, "msg_change");

        // Preemption by requester 1 after hold, then release to idle.
        req_i  = 2'b11;
        msg1_i = 16'h0F9E;
        step(20, "preempt");
        req_i = 2'b01;
        step(6, "r1_drop");

        // Simultaneous requests from IDLE.
        do_reset("rst_b");
        req_i  = 2'b11;
        msg0_i = 16'h1111;
        msg1_i = 16'h5678;
        step(1, "both_req");
        n_vec++;
        assert (gnt_o === 2'b10) else begin
            n_err++; $error("FAIL both_req_gnt got %b want 10", gnt_o);
        end
        step(20, "both_scan");

        // Requester 1 rises at hold cycle 3: switch exactly HOLD+1 edges after grant.
        do_reset("rst_c");
        req_i  = 2'b01;
        msg0_i = 16'hDCBA;
        msg1_i = 16'h2468;
        step(1, "hold_grant");
        step(3, "hold_early");
        req_i = 2'b11;
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1, "hold_wait");
            if (gnt_o == 2'b10) begin
                edges = 3 + i;
                break;
            end
        end
        n_vec++;
        assert (edges === HOLD + 1) else begin
            n_err++; $error("FAIL preempt_time got %0d want %0d", edges, HOLD + 1);
        end
        step(8, "hold_after");

        // Owner drops request after 2 cycles: released HOLD+1 edges after grant.
        do_reset("rst_d");
        req_i  = 2'b01;
        msg0_i = 16'h8888;
        step(1, "drop_grant");
        step(2, "drop_early");
        req_i = 2'b00;
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1, "drop_wait");
            if (busy_o == 1'b0) begin
                edges = 2 + i;
                break;
            end
        end
        n_vec++;
        assert (edges === HOLD + 1) else begin
            n_err++; $error("FAIL release_time got %0d want %0d", edges, HOLD + 1);
        end
        step(3, "drop_idle");

        // Mid-scan reset while owned, then re-arbitration.
        req_i  = 2'b01;
        msg0_i = 16'h4567;
        step(7, "pre_rst");
        #2;
        do_reset("mid_rst");
        step(10, "rearb");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req_i = 2'($urandom_range(0, 3));
            msg0_i = 16'($urandom);
            msg1_i = 16'($urandom);
            step(1, "random");
            if ($urandom_range(0, 299) == 0) do_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit scan step (legal range 2 to 2^20).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 100000000: minimum clk cycles a granted message stays owned (legal range 1 to 2^32-1).
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  2  display requests; bit 1 has higher priority than bit 0.
REQ-006 msg0  input  16  requester 0 message: four 4-bit glyph codes, bits [15:12] leftmost digit.
REQ-007 msg1  input  16  requester 1 message, same format as msg0.
REQ-008 gnt  output  2  one-hot grant; 2'b00 when no owner.
REQ-009 busy  output  1  high whenever a requester owns the display.
REQ-010 disp  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 an  output  4  digit anode enable, active-low, bit 0 rightmost.

Function
REQ-012 Glyph decode SHALL be: codes 0-9 standard digits (0=1000000, 8=0000000); A=C 1000110; B=L 1000111; C=S 0010010; D=E 0000110; E=dash 0111111; F=blank 1111111.
REQ-013 States SHALL be IDLE and OWN; busy = (state==OWN); gnt and busy registered.
REQ-014 In IDLE, if req!=0 at an edge, the block SHALL enter OWN at that edge, set gnt to the highest-priority requesting bit, snapshot that requester's msg into a 16-bit latch, and clear the hold counter.
REQ-015 In IDLE with req==2'b11, requester 1 SHALL be granted.
REQ-016 In OWN the hold counter SHALL increment each cycle, saturating at HOLD_CYCLES; the hold is satisfied when count==HOLD_CYCLES.
REQ-017 Before the hold is satisfied, gnt and the latch SHALL not change regardless of req.
REQ-018 Once satisfied, if owner is 0 and req[1]=1, the block SHALL switch gnt 01->10 in one edge, relatch msg1, and clear the hold counter (no IDLE cycle).
REQ-019 Once satisfied, if the owner's req bit is 0 and no preemption applies, the block SHALL return to IDLE with gnt=00 at that edge.
REQ-020 Requester 0 SHALL never preempt requester 1; an owner holding req high keeps the display indefinitely after its hold.
REQ-021 Changes to msg0/msg1 while owned SHALL not affect the display; only a new grant relatches.
REQ-022 A free-running prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the 2-bit digit index SHALL increment modulo 4, in all states.
REQ-023 Digit index 0,1,2,3 SHALL select an 1110,1101,1011,0111 and latch bits [3:0],[7:4],[11:8],[15:12] respectively.
REQ-024 disp and an SHALL be registered from the current state, digit index and latch, giving one cycle of latency after any of those changes.
REQ-025 In IDLE the block SHALL drive an=1111, disp=1111111.
REQ-026 At most one gnt bit SHALL ever be high; gnt!=00 iff busy=1.

Reset
REQ-027 While rst_n=0, outputs SHALL be asynchronously forced to gnt=00, busy=0, an=1111, disp=1111111; state=IDLE; prescaler, digit index, hold counter and latch cleared to 0.
REQ-028 Reset asserted mid-ownership SHALL discard the grant; after release the block SHALL re-arbitrate from IDLE on the first edge with req!=0.

Verification
REQ-029 Reset then req=01, msg0=16'hABCD, REFRESH_DIV=4 -> gnt=01 next edge; an cycles 1110/1101/1011/0111 every 4 clks with disp E(0000110), S(0010010), L(1000111), C(1000110).
REQ-030 IDLE, req=11 same edge -> gnt=10, msg1 displayed; gnt never 11.
REQ-031 Owner 0, HOLD_CYCLES=10, req[1] rises at hold cycle 3 -> gnt stays 01 until count reaches 10, then 10 on one edge, msg1 shown one cycle later.
REQ-032 Owner drops req after 2 cycles, HOLD_CYCLES=10 -> gnt held until count 10, then gnt=00, busy=0, an=1111 one cycle later.
REQ-033 msg0 changed to 16'h1234 while owned -> display unchanged; rst_n pulsed low mid-scan -> outputs blank immediately, no clock required.
